// File: rtl/ft245_ram_sender_pkg.sv
// Shared constants for the capture-RAM to FT245 sender: state codes, frame header
// bytes, FT245 minimum write-strobe timing and a word-to-byte helper.
package ft245_ram_sender_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_WAIT_TXE = 3'd2;
    localparam logic [2:0] ST_SETUP    = 3'd3;
    localparam logic [2:0] ST_PULSE    = 3'd4;
    localparam logic [2:0] ST_HOLD     = 3'd5;
    localparam logic [2:0] ST_NEXT     = 3'd6;
    localparam logic [2:0] ST_FIN      = 3'd7;

    localparam logic [7:0] HDR0_DEF = 8'hA5;
    localparam logic [7:0] HDR1_DEF = 8'h5A;

    localparam int FT_MIN_SETUP_CYCLES = 1;
    localparam int FT_MIN_PULSE_CYCLES = 3;

    // Little-endian byte pick: idx 0 is the ADC low byte, idx 3 the cos byte.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/ft245_ram_sender_if.sv
// Capture-side and FT245-side signals of the RAM sender; master is the sender,
// slave is the surrounding capture block / pin driver.
interface ft245_ram_sender_if #(
    parameter int ADDR_WIDTH = 11
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [31:0]           ram_data_out;
    logic                  ft_txe_n;
    logic                  ft_wr;
    logic [7:0]            ft_data;
    logic                  ft_data_oe;
    logic                  ft_rd_n;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, ram_data_out, ft_txe_n,
        output ram_rd_addr, ft_wr, ft_data, ft_data_oe, ft_rd_n, busy, done
    );

    modport slave (
        output start, ram_data_out, ft_txe_n,
        input  ram_rd_addr, ft_wr, ft_data, ft_data_oe, ft_rd_n, busy, done
    );
endinterface

// File: rtl/ft245_byte_writer.sv
// Writes one byte through the FT245 async write port: WAIT_TXE, SETUP, PULSE, HOLD.
// 1+SETUP+PULSE+1 cycles per byte with room; waits in WAIT_TXE while TXE# is high.
module ft245_byte_writer
    import ft245_ram_sender_pkg::*;
#(
    parameter int SETUP_CYCLES = FT_MIN_SETUP_CYCLES,
    parameter int PULSE_CYCLES = FT_MIN_PULSE_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [7:0] byte_in,
    input  logic       rel,
    input  logic       txe_n,
    output logic       ack,
    output logic       ft_wr,
    output logic [7:0] ft_data,
    output logic       ft_data_oe
);
    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);

    logic [1:0] txe_sync;
    logic [2:0] st;
    logic [7:0] cnt;

    // TXE# comes straight off the pins; reset to "full" so nothing leaves early.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txe_sync <= 2'b11;
        end else begin
            txe_sync <= {txe_sync[0], txe_n};
        end
    end

    assign ack = (st == ST_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= ST_WAIT_TXE;
            cnt        <= 8'd0;
            ft_wr      <= 1'b0;
            ft_data    <= 8'd0;
            ft_data_oe <= 1'b0;
        end else begin
            case (st)
                ST_WAIT_TXE: begin
                    if (req && !txe_sync[1]) begin
                        ft_data    <= byte_in;
                        ft_data_oe <= 1'b1;
                        cnt        <= 8'd0;
                        st         <= ST_SETUP;
                    end else if (rel) begin
                        ft_data_oe <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= 8'd0;
                        ft_wr <= 1'b1;
                        st    <= ST_PULSE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_PULSE: begin
                    // Once committed the strobe always completes, whatever TXE# does.
                    if (cnt == PULSE_LAST) begin
                        ft_wr <= 1'b0;
                        st    <= ST_HOLD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_HOLD: st <= ST_WAIT_TXE;
                default: st <= ST_WAIT_TXE;
            endcase
        end
    end
endmodule

// File: rtl/ft245_ram_sender.sv
// Streams a 2-byte header plus every capture-RAM word (4 bytes LE) to the FT245 after START.
// 7 cycles per byte plus RD_LATENCY+1 per word; stalls indefinitely while FT_TXE_N is high.
module ft245_ram_sender
    import ft245_ram_sender_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 11,
    parameter logic [ADDR_WIDTH-1:0] LAST_ADDR    = 11'd2047,
    parameter int                    RD_LATENCY   = 2,
    parameter int                    SETUP_CYCLES = FT_MIN_SETUP_CYCLES,
    parameter int                    PULSE_CYCLES = FT_MIN_PULSE_CYCLES,
    parameter logic [7:0]            HDR0         = HDR0_DEF,
    parameter logic [7:0]            HDR1         = HDR1_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ft245_ram_sender_if.master   bus
);
    logic [2:0]            st;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           word;
    logic [1:0]            byte_idx;
    logic [1:0]            hdr_phase;
    logic [7:0]            lat_cnt;
    logic                  busy;
    logic                  done;
    logic [7:0]            byte_val;
    logic                  ack;

    always_comb begin
        byte_val = word_byte(word, byte_idx);
        if (hdr_phase == 2'd2) begin
            byte_val = HDR0;
        end else if (hdr_phase == 2'd1) begin
            byte_val = HDR1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            addr      <= '0;
            word      <= 32'd0;
            byte_idx  <= 2'd0;
            hdr_phase <= 2'd0;
            lat_cnt   <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (bus.start) begin
                        addr      <= '0;
                        byte_idx  <= 2'd0;
                        hdr_phase <= 2'd2;
                        busy      <= 1'b1;
                        st        <= ST_WAIT_TXE;
                    end
                end
                ST_FETCH: begin
                    // addr changed on entry, so the word is valid after RD_LATENCY more edges.
                    if (lat_cnt == 8'(RD_LATENCY)) begin
                        word     <= bus.ram_data_out;
                        byte_idx <= 2'd0;
                        lat_cnt  <= 8'd0;
                        st       <= ST_WAIT_TXE;
                    end else begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                end
                ST_WAIT_TXE: begin
                    if (ack) begin
                        st <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (hdr_phase != 2'd0) begin
                        hdr_phase <= hdr_phase - 2'd1;
                        st        <= (hdr_phase == 2'd1) ? ST_FETCH : ST_WAIT_TXE;
                    end else if (byte_idx != 2'd3) begin
                        byte_idx <= byte_idx + 2'd1;
                        st       <= ST_WAIT_TXE;
                    end else if (addr == LAST_ADDR) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        st   <= ST_FIN;
                    end else begin
                        addr <= addr + ADDR_WIDTH'(1);
                        st   <= ST_FETCH;
                    end
                end
                ST_FIN: begin
                    done <= 1'b0;
                    st   <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    ft245_byte_writer #(
        .SETUP_CYCLES(SETUP_CYCLES),
        .PULSE_CYCLES(PULSE_CYCLES)
    ) u_writer (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (st == ST_WAIT_TXE),
        .byte_in    (byte_val),
        .rel        (st == ST_FIN),
        .txe_n      (bus.ft_txe_n),
        .ack        (ack),
        .ft_wr      (bus.ft_wr),
        .ft_data    (bus.ft_data),
        .ft_data_oe (bus.ft_data_oe)
    );

    assign bus.ram_rd_addr = addr;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.ft_rd_n     = 1'b1;
endmodule
